crc_arbiter: RTL and testbench

CRC_ARBITER -- requirements
Module: crc_arbiter

---
 rtl/crc_arbiter.sv | 112 +++++++++++
 tb/tb_crc_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_arbiter.sv
// Two-requester round-robin front end for a shared CRC engine: grants one frame at a
// time, streams its words into the engine and presents the captured checksum and length.
module crc_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int CRC_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req_valid,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic [1:0]            req_last,
    output logic [1:0]            req_ready,
    output logic                  crc_clr,
    output logic                  crc_en,
    output logic [DATA_WIDTH-1:0] crc_data,
    input  logic [CRC_WIDTH-1:0]  crc_result,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  res_id,
    output logic [CRC_WIDTH-1:0]  res_crc,
    output logic [7:0]            res_len
);

    typedef enum logic [2:0] {IDLE, CLR, STREAM, WAIT, RESULT} state_t;

    state_t                state, state_next;
    logic                  grant, grant_next;
    logic                  last_grant;
    logic [7:0]            count;
    logic                  sel_valid, sel_last, accept;
    logic [DATA_WIDTH-1:0] sel_data;

    assign sel_valid = grant ? req_valid[1] : req_valid[0];
    assign sel_last  = grant ? req_last[1]  : req_last[0];
    assign sel_data  = grant ? req_data1    : req_data0;

    always_comb begin
        state_next = state;
        grant_next = grant;
        req_ready  = 2'b00;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        crc_data   = '0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                // On contention the requester not served last wins; otherwise whoever asks.
                if (|req_valid) begin
                    grant_next = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
                    state_next = CLR;
                end
            end
            CLR: begin
                crc_clr    = 1'b1;
                state_next = STREAM;
            end
            STREAM: begin
                req_ready = grant ? 2'b10 : 2'b01;
                crc_en    = sel_valid;
                crc_data  = sel_data;
                accept    = sel_valid;
                if (sel_valid && sel_last) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The engine checksum settles during WAIT, so the result is captured on leaving it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            count      <= 8'd0;
            res_id     <= 1'b0;
            res_crc    <= '0;
            res_len    <= 8'd0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (state == CLR) begin
                count <= 8'd0;
            end else if (accept && (count != 8'hFF)) begin
                count <= count + 8'd1;
            end
            if (state == WAIT) begin
                res_crc <= crc_result;
                res_len <= count;
                res_id  <= grant;
            end
            if ((state == RESULT) && res_ready) begin
                last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_crc_arbiter.sv
// Self-checking bench for crc_arbiter: a cycle table, directed frame sequences and a
// randomized two-requester run, all scored against a frame-level model and a stub CRC-8 engine.
module tb_crc_arbiter;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [DW-1:0] req_data0 = '0;
    logic [DW-1:0] req_data1 = '0;
    logic [1:0]    req_last = 2'b00;
    logic [1:0]    req_ready;
    logic          crc_clr;
    logic          crc_en;
    logic [DW-1:0] crc_data;
    logic [CW-1:0] crc_result;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_id;
    logic [CW-1:0] res_crc;
    logic [7:0]    res_len;

    crc_arbiter #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data0(req_data0), .req_data1(req_data1), .req_last(req_last),
        .req_ready(req_ready), .crc_clr(crc_clr), .crc_en(crc_en), .crc_data(crc_data),
        .crc_result(crc_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_crc(res_crc), .res_len(res_len)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] crc8_word(input logic [7:0] acc_in, input logic [15:0] w);
        logic [7:0] acc;
        logic       fb;
        acc = acc_in;
        for (int b = 15; b >= 0; b--) begin
            fb  = acc[7] ^ w[b];
            acc = {acc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return acc;
    endfunction

    // Stub engine, deliberately not reset so a missing crc_clr corrupts the checksum.
    logic [7:0] engine_acc = 8'hA5;
    logic       stub_const = 1'b0;
    always @(posedge clk) begin
        if (crc_clr)     engine_acc <= 8'hFF;
        else if (crc_en) engine_acc <= crc8_word(engine_acc, crc_data);
    end
    assign crc_result = stub_const ? 8'h3C : engine_acc;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       id;
        logic [7:0] crc;
        logic [7:0] len;
    } res_t;

    res_t       exp_q[$];
    logic       grant_log[$];
    logic [7:0] m_crc [2];
    int         m_len [2];
    int         vis_delay;
    int         n_results;
    logic       last_grant_m, cur_grant_m, clr_seen;
    logic [1:0] prev_valid, prev_ready, xfer;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            m_crc[i] = 8'hFF;
            m_len[i] = 0;
        end
        vis_delay    = 0;
        last_grant_m = 1'b1;
        cur_grant_m  = 1'b0;
        clr_seen     = 1'b0;
        prev_valid   = 2'b00;
        prev_ready   = 2'b00;
        xfer         = 2'b00;
    endtask

    // Per-cycle scoring, called with this cycle's inputs applied and before the rising edge.
    task automatic observe();
        logic [1:0]  xf;
        logic        exp_rv;
        logic [15:0] w;
        res_t        r;
        exp_rv = (exp_q.size() > 0) && (vis_delay == 0);
        check_output("res_valid", res_valid, exp_rv);
        if (res_valid && exp_q.size() > 0) begin
            check_output("res_id", res_id, exp_q[0].id);
            check_output("res_crc", res_crc, exp_q[0].crc);
            check_output("res_len", res_len, exp_q[0].len);
        end
        check_output("clr_en_exclusive", crc_clr & crc_en, 0);
        check_output("crc_en", crc_en, |(req_valid & req_ready));
        if (crc_en) begin
            check_output("crc_data", crc_data, cur_grant_m ? req_data1 : req_data0);
        end
        if (crc_clr) begin
            check_output("clr_while_pending", exp_q.size(), 0);
            if (prev_valid == 2'b11) cur_grant_m = ~last_grant_m;
            else                     cur_grant_m = prev_valid[1];
            clr_seen = 1'b1;
        end
        if (req_ready != 2'b00) begin
            check_output("grant", req_ready, cur_grant_m ? 2'b10 : 2'b01);
            if (prev_ready == 2'b00) grant_log.push_back(req_ready[1]);
        end
        xf = req_valid & req_ready;
        for (int i = 0; i < 2; i++) begin
            if (xf[i]) begin
                check_output("clr_before_data", clr_seen, 1);
                w = (i == 1) ? req_data1 : req_data0;
                m_crc[i] = crc8_word(m_crc[i], w);
                m_len[i]++;
                if (req_last[i]) begin
                    r.id  = (i == 1);
                    r.crc = stub_const ? 8'h3C : m_crc[i];
                    r.len = (m_len[i] > 255) ? 8'd255 : 8'(m_len[i]);
                    exp_q.push_back(r);
                    vis_delay = 2;
                    clr_seen  = 1'b0;
                    m_crc[i]  = 8'hFF;
                    m_len[i]  = 0;
                end
            end
        end
        if (res_valid && res_ready && exp_q.size() > 0) begin
            r = exp_q.pop_front();
            last_grant_m = r.id;
            n_results++;
        end
        if (vis_delay > 0) vis_delay--;
        prev_valid = req_valid;
        prev_ready = req_ready;
        xfer       = xf;
    endtask

    task automatic tick();
        #2;
        observe();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        req_last  = 2'b00;
        res_ready = 1'b0;
        reset_n   = 1'b0;
        #1;
        check_output("rst_req_ready", req_ready, 0);
        check_output("rst_crc_clr", crc_clr, 0);
        check_output("rst_crc_en", crc_en, 0);
        check_output("rst_crc_data", crc_data, 0);
        check_output("rst_res_valid", res_valid, 0);
        check_output("rst_res_id", res_id, 0);
        check_output("rst_res_crc", res_crc, 0);
        check_output("rst_res_len", res_len, 0);
        model_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int id, input int nwords, input int gap_at, input int gap_len,
                             input int hold, input int exp_len);
        int   sent = 0;
        int   gap_left = gap_len;
        int   guard = 0;
        logic in_gap;
        res_ready = 1'b0;
        while (sent < nwords && guard < nwords + gap_len + 20) begin
            req_valid = 2'b00;
            req_last  = 2'b00;
            in_gap    = 1'b0;
            if (sent == gap_at && gap_left > 0) begin
                gap_left--;
                in_gap = 1'b1;
            end else begin
                req_valid[id] = 1'b1;
                req_last[id]  = (sent == nwords - 1);
                if (id == 0) req_data0 = 16'($urandom);
                else         req_data1 = 16'($urandom);
            end
            tick();
            guard++;
            if (in_gap) check_output("gap_crc_en", crc_en, 0);
            if (xfer[id]) sent++;
        end
        check_output("frame_words_sent", sent, nwords);
        req_valid = 2'b00;
        req_last  = 2'b00;
        guard = 0;
        while (!res_valid && guard < 10) begin
            tick();
            guard++;
        end
        check_output("result_seen", res_valid, 1);
        if (exp_len >= 0) check_output("frame_res_len", res_len, exp_len);
        for (int k = 0; k < hold; k++) begin
            req_valid = 2'b11;
            req_last  = 2'b11;
            tick();
        end
        req_valid = 2'b00;
        req_last  = 2'b00;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
    endtask

    typedef struct packed {
        logic [1:0]  valid;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [1:0]  last;
        logic        rr;
        logic [1:0]  e_ready;
        logic        e_clr;
        logic        e_en;
        logic [15:0] e_data;
        logic        e_rv;
        logic        e_rid;
        logic [7:0]  e_crc;
        logic [7:0]  e_len;
    } vec_t;

    vec_t table_v [9];

    task automatic apply_stimulus();
        int frames_left [2];
        int words_left  [2];
        int guard;
        int results_before;
        // Cycle table for one two-word frame from requester 0 with a constant engine result.
        table_v[0] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'd0};
        table_v[1] = '{2'b01, 16'h1234, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'd0};
        table_v[2] = '{2'b01, 16'h1234, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'd0};
        table_v[3] = '{2'b01, 16'h1234, 16'h0000, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 8'h00, 8'd0};
        table_v[4] = '{2'b01, 16'h5678, 16'h0000, 2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0, 8'h00, 8'd0};
        table_v[5] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'd0};
        table_v[6] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h3C, 8'd2};
        table_v[7] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h3C, 8'd2};
        table_v[8] = '{2'b00, 16'h0000, 16'h0000, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 8'd0};

        stub_const = 1'b1;
        do_reset();
        for (int r = 0; r < 9; r++) begin
            req_valid = table_v[r].valid;
            req_data0 = table_v[r].d0;
            req_data1 = table_v[r].d1;
            req_last  = table_v[r].last;
            res_ready = table_v[r].rr;
            #2;
            check_output($sformatf("tbl%0d_ready", r), req_ready, table_v[r].e_ready);
            check_output($sformatf("tbl%0d_clr", r), crc_clr, table_v[r].e_clr);
            check_output($sformatf("tbl%0d_en", r), crc_en, table_v[r].e_en);
            if (table_v[r].e_en) check_output($sformatf("tbl%0d_data", r), crc_data, table_v[r].e_data);
            check_output($sformatf("tbl%0d_res_valid", r), res_valid, table_v[r].e_rv);
            if (table_v[r].e_rv) begin
                check_output($sformatf("tbl%0d_res_id", r), res_id, table_v[r].e_rid);
                check_output($sformatf("tbl%0d_res_crc", r), res_crc, table_v[r].e_crc);
                check_output($sformatf("tbl%0d_res_len", r), res_len, table_v[r].e_len);
            end
            observe();
            @(negedge clk);
            #1;
        end
        stub_const = 1'b0;

        // Both requesters continuously asking with one-word frames: grants must alternate 0,1,0,1.
        do_reset();
        grant_log.delete();
        req_valid = 2'b11;
        req_last  = 2'b11;
        res_ready = 1'b1;
        guard = 0;
        while (grant_log.size() < 4 && guard < 60) begin
            req_data0 = 16'($urandom);
            req_data1 = 16'($urandom);
            tick();
            guard++;
        end
        req_valid = 2'b00;
        req_last  = 2'b00;
        for (int k = 0; k < 4; k++) tick();
        res_ready = 1'b0;
        check_output("rr_grant_count", grant_log.size(), 4);
        for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
            check_output($sformatf("rr_grant%0d", k), grant_log[k], k % 2);
        end

        // Gap of three idle cycles mid-frame, a held result, and a saturating long frame.
        run_frame(1, 6, 2, 3, 0, 6);
        run_frame(0, 3, -1, 0, 5, 3);
        run_frame(1, 300, -1, 0, 0, 255);

        // Reset in the middle of a frame, then a fresh frame that must clear the engine first.
        req_valid = 2'b10;
        req_last  = 2'b00;
        guard = 0;
        while (guard < 10 && m_len[1] < 2) begin
            req_data1 = 16'($urandom);
            tick();
            guard++;
        end
        check_output("pre_reset_words", m_len[1], 2);
        do_reset();
        tick();
        run_frame(1, 2, -1, 0, 0, 2);

        // Randomized traffic from both requesters with random consumer backpressure.
        results_before = n_results;
        for (int i = 0; i < 2; i++) begin
            frames_left[i] = 8;
            words_left[i]  = $urandom_range(1, 6);
        end
        guard = 0;
        while (guard < 4000 && (frames_left[0] + frames_left[1] + exp_q.size()) != 0) begin
            for (int i = 0; i < 2; i++) begin
                req_valid[i] = (frames_left[i] > 0) && ($urandom_range(0, 3) != 0);
                req_last[i]  = (words_left[i] == 1);
            end
            req_data0 = 16'($urandom);
            req_data1 = 16'($urandom);
            res_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
            for (int i = 0; i < 2; i++) begin
                if (xfer[i]) begin
                    words_left[i]--;
                    if (words_left[i] == 0) begin
                        frames_left[i]--;
                        words_left[i] = $urandom_range(1, 6);
                    end
                end
            end
        end
        req_valid = 2'b00;
        req_last  = 2'b00;
        res_ready = 1'b0;
        tick();
        check_output("random_all_done", frames_left[0] + frames_left[1] + exp_q.size(), 0);
        check_output("random_results", n_results - results_before, 16);
    endtask

    initial begin
        n_results = 0;
        model_reset();
        #2;
        apply_stimulus();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
